// File: rtl/probe_display_ctrl.sv
// probe_display_ctrl: shows one of NUM_CH probe words on NUM_DIGITS
// seven-segment digits (active-low). Two debounced pushbuttons step the
// channel and the nibble page; auto_rotate cycles through the channels.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blank leading zeros on page 0).
//
// key_evt is a 1-cycle pulse per accepted press; there is no back-pressure:
// a pulse is consumed by the channel/page registers on the following edge.
module probe_display_ctrl #(
  parameter int NUM_CH        = 5,
  parameter int DATA_W        = 32,
  parameter int NUM_DIGITS    = 6,
  parameter int DEB_CYCLES    = 500000,
  parameter int ROTATE_CYCLES = 50000000,
  localparam int NPAGES = (DATA_W + 4*NUM_DIGITS - 1) / (4*NUM_DIGITS),
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PG_W   = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*DATA_W-1:0] probe_data,
  input  logic                     key_next_n,
  input  logic                     key_page_n,
  input  logic                     auto_rotate,
  output logic [NUM_DIGITS*7-1:0]  hex,
  output logic [CH_W-1:0]          ch_sel,
  output logic [PG_W-1:0]          page_sel,
  output logic [1:0]               key_evt
);

  localparam int NNIB  = DATA_W / 4;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int ROT_W = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;

  // Index 0 = next key, index 1 = page key (matches key_evt bit order).
  logic [1:0]       keys_n;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb_state;
  logic [DEB_W-1:0] deb_cnt [2];

  logic [ROT_W-1:0] rot_cnt;
  logic             rot_wrap;
  logic             next_evt;
  logic             page_evt;

  logic [DATA_W-1:0]       word;
  logic [NUM_DIGITS*7-1:0] hex_next;
  logic [3:0]              nib;
  logic                    nib_valid;
  logic [6:0]              seg;
`ifdef LEAD_ZERO_BLANK_EN
  int                      lz_top;
`endif

  assign keys_n   = {key_page_n, key_next_n};
  assign next_evt = key_evt[0];
  assign page_evt = key_evt[1];

  // Hex digit to active-low gfedcba segments.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // Synchronise both keys, debounce, and pulse key_evt on a flip to pressed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      deb_state <= 2'b11;
      key_evt   <= 2'b00;
      for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
    end else begin
      sync1   <= keys_n;
      sync2   <= sync1;
      key_evt <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == deb_state[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_cnt[k]   <= '0;
          deb_state[k] <= sync2[k];
          key_evt[k]   <= ~sync2[k];
        end else begin
          deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
        end
      end
    end
  end

  // A manual next takes priority over (and restarts) the auto-rotate dwell.
  assign rot_wrap = auto_rotate && !next_evt &&
                    (rot_cnt == ROT_W'(ROTATE_CYCLES - 1));

  // Auto-rotate dwell counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rot_cnt <= '0;
    end else if (!auto_rotate || next_evt || rot_wrap) begin
      rot_cnt <= '0;
    end else begin
      rot_cnt <= rot_cnt + ROT_W'(1);
    end
  end

  // Channel and page selection; a next action always returns to page 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch_sel   <= '0;
      page_sel <= '0;
    end else if (next_evt || rot_wrap) begin
      ch_sel   <= (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + CH_W'(1);
      page_sel <= '0;
    end else if (page_evt) begin
      page_sel <= (page_sel == PG_W'(NPAGES - 1)) ? '0 : page_sel + PG_W'(1);
    end
  end

  // Select the displayed word and decode the current page into segments.
  always_comb begin
    word      = '0;
    hex_next  = '0;
    nib       = '0;
    nib_valid = 1'b0;
    seg       = 7'h7F;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == CH_W'(c)) word = probe_data[c*DATA_W +: DATA_W];
    end
`ifdef LEAD_ZERO_BLANK_EN
    lz_top = 0;
    for (int k = 0; k < NNIB; k++) begin
      if (word[4*k +: 4] != 4'h0) lz_top = k;
    end
`endif
    for (int d = 0; d < NUM_DIGITS; d++) begin
      nib       = '0;
      nib_valid = 1'b0;
      for (int k = 0; k < NNIB; k++) begin
        if (int'(page_sel) * NUM_DIGITS + d == k) begin
          nib       = word[4*k +: 4];
          nib_valid = 1'b1;
        end
      end
      seg = nib_valid ? seg7(nib) : 7'h7F;
`ifdef LEAD_ZERO_BLANK_EN
      if (page_sel == '0 && d > lz_top) seg = 7'h7F;
`endif
      hex_next[d*7 +: 7] = seg;
    end
  end

  // Registered segment outputs, blank in reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hex <= {NUM_DIGITS{7'h7F}};
    end else begin
      hex <= hex_next;
    end
  end

endmodule

// File: tb/tb_probe_display_ctrl.sv
// Bench for probe_display_ctrl: directed steps followed by a randomized
// phase, every cycle checked against a cycle-level behavioural model.
module tb_probe_display_ctrl;

  localparam int NUM_CH = 5;
  localparam int DATA_W = 32;
  localparam int NUM_DIGITS = 6;
  localparam int DEB = 4;
  localparam int ROT = 16;
  localparam int NPAGES = 2;
  localparam logic [41:0] BLANK = {6{7'h7F}};

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_n;
  logic [NUM_CH*DATA_W-1:0] probe_data;
  logic                     key_next_n;
  logic                     key_page_n;
  logic                     auto_rotate;
  logic [41:0]              hex;
  logic [2:0]               ch_sel;
  logic [0:0]               page_sel;
  logic [1:0]               key_evt;

  probe_display_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS),
    .DEB_CYCLES(DEB), .ROTATE_CYCLES(ROT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .probe_data(probe_data),
    .key_next_n(key_next_n), .key_page_n(key_page_n),
    .auto_rotate(auto_rotate), .hex(hex), .ch_sel(ch_sel),
    .page_sel(page_sel), .key_evt(key_evt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rand_probe = 1'b0;

  // reference model state
  int          m_ch, m_page, m_dwell;
  logic [1:0]  m_evt;
  int          evt_at [2];
  logic [41:0] m_hex;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Expected segments for a word shown on a page.
  function automatic logic [41:0] model_hex(input logic [31:0] w, input int page);
    logic [41:0] r;
    logic [3:0]  nb;
    int n;
`ifdef LEAD_ZERO_BLANK_EN
    int top;
    top = 0;
    for (int k = 0; k < 8; k++) if (4'(w >> (4*k)) != 4'h0) top = k;
`endif
    r = BLANK;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      n = page * NUM_DIGITS + d;
      if (n < DATA_W / 4) begin
        nb = 4'(w >> (4*n));
        r[d*7 +: 7] = seg_tab[nb];
      end
`ifdef LEAD_ZERO_BLANK_EN
      if (page == 0 && d > top) r[d*7 +: 7] = 7'h7F;
`endif
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model for this edge, then compare all outputs.
  task automatic tick();
    logic adv;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      m_ch = 0; m_page = 0; m_dwell = 0; m_evt = 2'b00;
      evt_at[0] = -1; evt_at[1] = -1;
      m_hex = BLANK;
    end else begin
      m_hex = model_hex(probe_data[m_ch*DATA_W +: DATA_W], m_page);
      adv = m_evt[0];
      if (auto_rotate) begin
        if (m_evt[0]) m_dwell = 0;
        else begin
          m_dwell++;
          if (m_dwell == ROT) begin adv = 1'b1; m_dwell = 0; end
        end
      end else begin
        m_dwell = 0;
      end
      if (adv) begin m_ch = (m_ch + 1) % NUM_CH; m_page = 0; end
      else if (m_evt[1]) m_page = (m_page + 1) % NPAGES;
      m_evt = {logic'(evt_at[1] == cyc), logic'(evt_at[0] == cyc)};
    end
    #1;
    chk("hex", 64'(hex), 64'(m_hex));
    chk("ch_sel", 64'(ch_sel), 64'(m_ch));
    chk("page_sel", 64'(page_sel), 64'(m_page));
    chk("key_evt", 64'(key_evt), 64'(m_evt));
    if (rand_probe) probe_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // driver: hold the selected keys low for 'low' cycles, then idle 'gap' cycles.
  task automatic press(input logic do_next, input logic do_page, input int low, input int gap);
    if (low >= DEB) begin
      if (do_next) evt_at[0] = cyc + 2 + DEB;
      if (do_page) evt_at[1] = cyc + 2 + DEB;
    end
    key_next_n = ~do_next;
    key_page_n = ~do_page;
    repeat (low) tick();
    key_next_n = 1'b1;
    key_page_n = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    m_ch = 0; m_page = 0; m_dwell = 0; m_evt = 2'b00;
    evt_at[0] = -1; evt_at[1] = -1; m_hex = BLANK;
    key_next_n = 1'b1; key_page_n = 1'b1; auto_rotate = 1'b0;
    probe_data = {$urandom(), $urandom(), $urandom(), $urandom(), 32'h1234_5678};

    // reset: blank during reset, word shown one cycle after release
    do_reset(3);
    chk("hex_in_reset", 64'(hex), 64'(BLANK));
    tick();
    chk("hex_after_reset", 64'(hex), 64'({7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    chk("ch_after_reset", 64'(ch_sel), 64'd0);

    // debounce: 3-cycle glitch ignored, 4 cycles is the shortest accepted press
    press(1'b1, 1'b0, 3, 12);
    chk("glitch_no_change", 64'(ch_sel), 64'd0);
    press(1'b1, 1'b0, 10, 12);
    chk("first_next", 64'(ch_sel), 64'd1);
    press(1'b1, 1'b0, 4, 12);
    press(1'b1, 1'b0, 5, 12);
    press(1'b1, 1'b0, 6, 12);
    chk("ch_at_last", 64'(ch_sel), 64'd4);
    press(1'b1, 1'b0, 5, 12);
    chk("ch_wrap", 64'(ch_sel), 64'd0);

    // paging on ch0
    probe_data[31:0] = 32'hDEAD_BEEF;
    press(1'b0, 1'b1, 5, 12);
    chk("page1_hex", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h21, 7'h06}));
    press(1'b0, 1'b1, 5, 12);
    chk("page_wrap", 64'(page_sel), 64'd0);

    // simultaneous presses: next wins, page returns to 0
    press(1'b0, 1'b1, 5, 12);
    press(1'b1, 1'b1, 6, 12);
    chk("simul_ch", 64'(ch_sel), 64'd1);
    chk("simul_page", 64'(page_sel), 64'd0);

    // auto-rotate, then a manual next part-way through a dwell
    auto_rotate = 1'b1;
    repeat (3 * ROT) tick();
    chk("auto_three_steps", 64'(ch_sel), 64'd4);
    repeat (4) tick();
    press(1'b1, 1'b0, 5, 40);
    auto_rotate = 1'b0;
    repeat (4) tick();

    // reset in the middle of a debounce discards the partial count
    key_next_n = 1'b0;
    repeat (4) tick();
    key_next_n = 1'b1;
    do_reset(2);
    repeat (12) tick();
    chk("reset_mid_debounce", 64'(ch_sel), 64'd0);

    // randomized phase
    rand_probe = 1'b1;
    for (int i = 0; i < 40; i++) begin
      auto_rotate = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: press(1'b1, 1'b0, $urandom_range(1, 9), $urandom_range(10, 14));
        1: press(1'b0, 1'b1, $urandom_range(1, 9), $urandom_range(10, 14));
        default: press(1'b1, 1'b1, $urandom_range(1, 9), $urandom_range(10, 14));
      endcase
    end
    rand_probe = 1'b0;
    auto_rotate = 1'b0;

    // leading-zero handling on page 0
    do_reset(2);
    probe_data[31:0] = 32'h0000_00A0;
    repeat (2) tick();
`ifdef LEAD_ZERO_BLANK_EN
    chk("lz_a0", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40}));
    probe_data[31:0] = 32'h0;
    repeat (2) tick();
    chk("lz_zero", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
`else
    chk("zeros_a0", 64'(hex), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40}));
    probe_data[31:0] = 32'h0;
    repeat (2) tick();
    chk("zeros_zero", 64'(hex), 64'({6{7'h40}}));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
